button_gesture_ctrl: RTL and testbench

//   Classifies the debounced push-button level into short-press, double-press and long-press events.

---
 rtl/button_gesture_ctrl.sv | 175 +++++++++++++++++
 tb/tb_button_gesture_ctrl.sv | 225 ++++++++++++++++++++++
 2 files changed

// File: rtl/button_gesture_ctrl.sv
// button_gesture_ctrl
//   Turns the debounced push-button level into short, double and long press
//   events and steps the 7-segment display mode from them. Every output comes
//   straight from a register.
module button_gesture_ctrl #(
  parameter int unsigned LONG_CYCLES       = 25_000_000,
  parameter int unsigned DOUBLE_GAP_CYCLES = 12_500_000,
  parameter int unsigned CNT_W             = 25,
  parameter int unsigned NUM_MODES         = 8,
  parameter int unsigned MODE_W            = 3
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              btn_level,
  output logic              short_pulse,
  output logic              double_pulse,
  output logic              long_pulse,
  output logic              held,
  output logic [MODE_W-1:0] mode
);

  typedef enum logic [2:0] {
    IDLE      = 3'd0,
    PRESS1    = 3'd1,
    WAIT2     = 3'd2,
    PRESS2    = 3'd3,
    LONG_HELD = 3'd4
  } state_t;

  localparam logic [CNT_W-1:0]  LONG_LAST = CNT_W'(LONG_CYCLES - 1);
  localparam logic [CNT_W-1:0]  GAP_LAST  = CNT_W'(DOUBLE_GAP_CYCLES - 1);
  localparam logic [MODE_W-1:0] MODE_LAST = MODE_W'(NUM_MODES - 1);

  // Next mode after a short press; wraps at NUM_MODES, not at 2^MODE_W.
  function automatic logic [MODE_W-1:0] mode_inc(input logic [MODE_W-1:0] m);
    if (m >= MODE_LAST) begin
      return {MODE_W{1'b0}};
    end else begin
      return m + MODE_W'(1);
    end
  endfunction

  // Next mode after a double press; 0 wraps to the last valid mode.
  function automatic logic [MODE_W-1:0] mode_dec(input logic [MODE_W-1:0] m);
    if (m == {MODE_W{1'b0}}) begin
      return MODE_LAST;
    end else begin
      return m - MODE_W'(1);
    end
  endfunction

  state_t            state_r, state_nxt_s;
  logic [CNT_W-1:0]  cnt_r, cnt_nxt_s;
  logic              btn_prev_r;
  logic              rise_s, fall_s;
  logic              short_s, double_s, long_s;
  logic [MODE_W-1:0] mode_r, mode_nxt_s;
  logic              short_r, double_r, long_r, held_r;

  assign rise_s = btn_level & ~btn_prev_r;
  assign fall_s = ~btn_level & btn_prev_r;

  // Gesture FSM: next state and the single-cycle event strobes.
  always_comb begin
    state_nxt_s = state_r;
    short_s     = 1'b0;
    double_s    = 1'b0;
    long_s      = 1'b0;
    case (state_r)
      IDLE: begin
        if (rise_s) begin
          state_nxt_s = PRESS1;
        end else begin
          state_nxt_s = IDLE;
        end
      end
      PRESS1: begin
        if (fall_s) begin
          state_nxt_s = WAIT2;
        end else if (btn_level && (cnt_r == LONG_LAST)) begin
          state_nxt_s = LONG_HELD;
          long_s      = 1'b1;
        end else begin
          state_nxt_s = PRESS1;
        end
      end
      WAIT2: begin
        // A second press on the very last gap cycle still counts as double.
        if (rise_s) begin
          state_nxt_s = PRESS2;
        end else if (cnt_r == GAP_LAST) begin
          state_nxt_s = IDLE;
          short_s     = 1'b1;
        end else begin
          state_nxt_s = WAIT2;
        end
      end
      PRESS2: begin
        if (fall_s) begin
          state_nxt_s = IDLE;
          double_s    = 1'b1;
        end else begin
          state_nxt_s = PRESS2;
        end
      end
      LONG_HELD: begin
        if (fall_s) begin
          state_nxt_s = IDLE;
        end else begin
          state_nxt_s = LONG_HELD;
        end
      end
      default: begin
        state_nxt_s = IDLE;
      end
    endcase
  end

  // Timer: cleared on every state change, counts only in the timed states.
  always_comb begin
    cnt_nxt_s = cnt_r;
    if (state_nxt_s != state_r) begin
      cnt_nxt_s = {CNT_W{1'b0}};
    end else if ((state_r == PRESS1) || (state_r == WAIT2)) begin
      cnt_nxt_s = cnt_r + CNT_W'(1);
    end else begin
      cnt_nxt_s = cnt_r;
    end
  end

  // Mode stepping from the event strobes; long press forces mode 0.
  always_comb begin
    mode_nxt_s = mode_r;
    if (long_s) begin
      mode_nxt_s = {MODE_W{1'b0}};
    end else if (short_s) begin
      mode_nxt_s = mode_inc(mode_r);
    end else if (double_s) begin
      mode_nxt_s = mode_dec(mode_r);
    end else begin
      mode_nxt_s = mode_r;
    end
  end

  // State, timer, edge history and registered outputs. btn_prev resets to 1 so
  // a button held through reset must be released before it can press again.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_r    <= IDLE;
      cnt_r      <= {CNT_W{1'b0}};
      btn_prev_r <= 1'b1;
      mode_r     <= {MODE_W{1'b0}};
      short_r    <= 1'b0;
      double_r   <= 1'b0;
      long_r     <= 1'b0;
      held_r     <= 1'b0;
    end else begin
      state_r    <= state_nxt_s;
      cnt_r      <= cnt_nxt_s;
      btn_prev_r <= btn_level;
      mode_r     <= mode_nxt_s;
      short_r    <= short_s;
      double_r   <= double_s;
      long_r     <= long_s;
      held_r     <= (state_nxt_s == LONG_HELD);
    end
  end

  assign short_pulse  = short_r;
  assign double_pulse = double_r;
  assign long_pulse   = long_r;
  assign held         = held_r;
  assign mode         = mode_r;

endmodule

// File: tb/tb_button_gesture_ctrl.sv
// Directed bench for button_gesture_ctrl with small timing parameters.
module tb_button_gesture_ctrl;

  localparam int unsigned LONG_C = 16;
  localparam int unsigned GAP_C  = 8;
  localparam int unsigned NM     = 4;
  localparam int unsigned MW     = 2;
  localparam int unsigned CW     = 5;

  logic          clk;
  logic          reset;
  logic          btn_level;
  logic          short_pulse;
  logic          double_pulse;
  logic          long_pulse;
  logic          held;
  logic [MW-1:0] mode;

  int n_checks = 0;
  int n_fail   = 0;
  int n_short  = 0;
  int n_double = 0;
  int n_long   = 0;

  button_gesture_ctrl #(
    .LONG_CYCLES(LONG_C),
    .DOUBLE_GAP_CYCLES(GAP_C),
    .CNT_W(CW),
    .NUM_MODES(NM),
    .MODE_W(MW)
  ) dut (
    .clk(clk),
    .reset(reset),
    .btn_level(btn_level),
    .short_pulse(short_pulse),
    .double_pulse(double_pulse),
    .long_pulse(long_pulse),
    .held(held),
    .mode(mode)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input int unsigned obs, input int unsigned exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d", tag, obs, exp);
    end
  endtask

  // one clock edge, then settle; tally any pulses seen
  task automatic tick();
    @(posedge clk);
    #1;
    if (short_pulse === 1'b1)  n_short++;
    if (double_pulse === 1'b1) n_double++;
    if (long_pulse === 1'b1)   n_long++;
  endtask

  task automatic step(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  task automatic clr_counts();
    n_short  = 0;
    n_double = 0;
    n_long   = 0;
  endtask

  task automatic do_reset();
    reset     = 1'b1;
    btn_level = 1'b0;
    step(2);
    reset = 1'b0;
    tick();
    clr_counts();
  endtask

  // btn high for n edges, then low (no edge taken after release)
  task automatic press(input int n);
    btn_level = 1'b1;
    step(n);
    btn_level = 1'b0;
  endtask

  // isolated short press ending with the short pulse just observed
  task automatic short_press();
    press(2);
    step(GAP_C + 1);
  endtask

  initial begin
    reset     = 1'b1;
    btn_level = 1'b0;

    // ---------------- Reset state ----------------
    step(2);
    chk("rst_mode", mode, 0);
    chk("rst_held", held, 0);
    chk("rst_pulses", {short_pulse, double_pulse, long_pulse}, 0);
    reset = 1'b0;
    tick();
    clr_counts();

    // ---------------- 1. Short press ----------------
    press(5);
    step(GAP_C);                     // fall edge + 7 gap edges
    chk("t1_early_short", n_short, 0);
    tick();                          // 8th edge after WAIT2 entry
    chk("t1_short", short_pulse, 1);
    chk("t1_mode", mode, 1);
    tick();
    chk("t1_short_1cyc", short_pulse, 0);
    chk("t1_others", n_double + n_long, 0);

    // ---------------- 2/3. Wrap and double press ----------------
    do_reset();
    short_press();
    chk("t2_mode1", mode, 1);
    step(3);
    short_press();
    chk("t2_mode2", mode, 2);
    step(3);
    short_press();
    chk("t2_mode3", mode, 3);
    step(3);
    short_press();
    chk("t2_mode0", mode, 0);
    step(3);
    clr_counts();
    press(3);
    step(3);
    press(3);
    tick();                          // edge after the second fall
    chk("t3_double", double_pulse, 1);
    chk("t3_mode", mode, 3);
    tick();
    chk("t3_double_1cyc", double_pulse, 0);
    step(12);
    chk("t3_no_short", n_short, 0);
    chk("t3_double_cnt", n_double, 1);

    // ---------------- 4. Long press ----------------
    do_reset();
    short_press();
    step(3);
    short_press();
    step(3);
    chk("t4_premode", mode, 2);
    clr_counts();
    btn_level = 1'b1;
    step(LONG_C);                    // entry edge + 15 more
    chk("t4_early_long", n_long, 0);
    tick();                          // 16 edges after PRESS1 entry
    chk("t4_long", long_pulse, 1);
    chk("t4_mode", mode, 0);
    chk("t4_held", held, 1);
    step(40 - LONG_C - 1);
    chk("t4_held_still", held, 1);
    chk("t4_long_once", n_long, 1);
    btn_level = 1'b0;
    tick();
    chk("t4_held_rel", held, 0);
    step(12);
    chk("t4_no_rel_pulse", n_short + n_double, 0);
    chk("t4_mode_end", mode, 0);

    // ---------------- 5. Gap boundary ----------------
    do_reset();
    press(2);
    step(GAP_C);                     // fall edge + 7 edges: cnt now 7
    btn_level = 1'b1;
    tick();                          // rise on the cnt==7 edge
    chk("t5_no_short", short_pulse, 0);
    step(2);
    btn_level = 1'b0;
    tick();
    chk("t5_double", double_pulse, 1);
    chk("t5_mode_dbl", mode, 3);
    chk("t5_short_cnt", n_short, 0);
    step(3);
    clr_counts();
    press(2);
    step(GAP_C + 1);                 // timeout fires on the 8th gap edge
    chk("t5_late_short", short_pulse, 1);
    chk("t5_mode_wrap", mode, 0);
    btn_level = 1'b1;
    tick();                          // rise one cycle later -> new PRESS1
    step(2);
    btn_level = 1'b0;
    step(GAP_C + 1);
    chk("t5_new_short", short_pulse, 1);
    chk("t5_mode_new", mode, 1);
    chk("t5_dbl_cnt", n_double, 0);

    // ---------------- 6. Reset mid-press ----------------
    do_reset();
    short_press();
    step(3);
    clr_counts();
    btn_level = 1'b1;
    step(10);
    reset = 1'b1;
    step(2);
    chk("t6_rst_mode", mode, 0);
    chk("t6_rst_held", held, 0);
    reset = 1'b0;
    step(30);
    chk("t6_held", held, 0);
    btn_level = 1'b0;
    step(12);
    chk("t6_no_pulses", n_short + n_double + n_long, 0);
    chk("t6_mode", mode, 0);
    press(2);
    step(GAP_C + 1);
    chk("t6_fresh_short", short_pulse, 1);
    chk("t6_fresh_mode", mode, 1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
